// File: rtl/seg7_to_bcd_rx.sv
// Seven-segment (active-low) receiver: synchronizes the segment lines, waits for a
// stable pattern and decodes it to BCD. Define SEG7_HEX_EN to also accept A..F.
module seg7_to_bcd_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [3:0] digit,
  output logic       valid,
  output logic       err,
  output logic       blank,
  output logic [7:0] digit_cnt
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK_PAT = 7'h7F;

  logic [6:0] sync1_q, sync2_q, p_q;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic       blank_q, blank_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [4:0] dec_s;

  // Returns {err, digit}; anything unrecognised maps to {1, F}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h01:   r = 5'h00;
      7'h4F:   r = 5'h01;
      7'h12:   r = 5'h02;
      7'h06:   r = 5'h03;
      7'h4C:   r = 5'h04;
      7'h24:   r = 5'h05;
      7'h20:   r = 5'h06;
      7'h0F:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h04:   r = 5'h09;
`ifdef SEG7_HEX_EN
      7'h08:   r = 5'h0A;
      7'h60:   r = 5'h0B;
      7'h31:   r = 5'h0C;
      7'h42:   r = 5'h0D;
      7'h30:   r = 5'h0E;
      7'h38:   r = 5'h0F;
`endif
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    err_d   = err_q;
    valid_d = 1'b0;
    blank_d = blank_q;
    dcnt_d  = dcnt_q;
    dec_s   = decode(sync2_q);
    if (sync2_q != p_q) begin
      state_d = SETTLE;
      cnt_d   = 8'd0;
      blank_d = 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == LAST_CNT) begin
            state_d = LOCKED;
            if (sync2_q == BLANK_PAT) begin
              blank_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              digit_d = dec_s[3:0];
              err_d   = dec_s[4];
              dcnt_d  = dcnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        LOCKED:  state_d = LOCKED;
        default: state_d = SETTLE;
      endcase
    end
  end

  // Synchronizers, previous-sample register, FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BLANK_PAT;
      sync2_q <= BLANK_PAT;
      p_q     <= BLANK_PAT;
      state_q <= SETTLE;
      cnt_q   <= 8'd0;
      digit_q <= 4'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
      dcnt_q  <= 8'd0;
    end else begin
      sync1_q <= {a, b, c, d, e, f, g};
      sync2_q <= sync1_q;
      p_q     <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign digit     = digit_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign blank     = blank_q;
  assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_seg7_to_bcd_rx.sv
// Directed bench for seg7_to_bcd_rx with a scoreboard of expected valid pulses.
module tb_seg7_to_bcd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a, b, c, d, e, f, g;
  logic [3:0] digit;
  logic       valid, err, blank;
  logic [7:0] digit_cnt;

  int passed = 0;
  int total  = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [12:0] sb[$];
  logic [6:0]  codes [10];
  logic [7:0]  cnt_snap;

  seg7_to_bcd_rx #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .digit(digit), .valid(valid), .err(err), .blank(blank), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put(input logic [6:0] code);
    @(posedge clk); #1;
    {a, b, c, d, e, f, g} = code;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_valid(input logic [3:0] dg, input logic er);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back({dg, er, exp_cnt});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_cnt = 8'd0;
    #1;
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_digit", {12'd0, digit}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_blank", {15'd0, blank}, 16'd0);
    check("rst_cnt", {8'd0, digit_cnt}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {15'd0, valid}, 16'd0);
      end else begin
        logic [12:0] x;
        x = sb.pop_front();
        check("sb_digit", {12'd0, digit}, {12'd0, x[12:9]});
        check("sb_err", {15'd0, err}, {15'd0, x[8]});
        check("sb_cnt", {8'd0, digit_cnt}, {8'd0, x[7:0]});
      end
    end
  end

  initial begin
    codes = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    {a, b, c, d, e, f, g} = 7'h7F;
    do_reset();

    // Constant blank after reset.
    wait_cyc(10);
    check("post_rst_blank", {15'd0, blank}, 16'd1);
    check("post_rst_digit", {12'd0, digit}, 16'd0);

    // Digit 3: exact latency, valid after the 7th edge following the drive.
    put(7'h06);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("lat_early", {15'd0, valid}, 16'd0);
    end
    expect_valid(4'd3, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", {15'd0, valid}, 16'd1);
    check("lat_blank", {15'd0, blank}, 16'd0);
    @(posedge clk); #1;
    check("pulse_one_cycle", {15'd0, valid}, 16'd0);
    wait_cyc(4);
    check("cnt_one", {8'd0, digit_cnt}, 16'd1);

    // Fast toggling is never accepted.
    cnt_snap = digit_cnt;
    for (int i = 0; i < 20; i++) begin
      put((i % 2) ? 7'h4F : 7'h01);
      wait_cyc(1);
    end
    check("toggle_cnt", {8'd0, digit_cnt}, {8'd0, cnt_snap});
    check("toggle_digit", {12'd0, digit}, 16'd3);

    // Blank after digit 7 keeps digit; then 8 clears blank.
    put(7'h0F); expect_valid(4'd7, 1'b0); wait_cyc(10);
    put(7'h7F); wait_cyc(10);
    check("blank_set", {15'd0, blank}, 16'd1);
    check("blank_digit_kept", {12'd0, digit}, 16'd7);
    check("blank_cnt_kept", {8'd0, digit_cnt}, {8'd0, exp_cnt});
    put(7'h00); expect_valid(4'd8, 1'b0); wait_cyc(3);
    check("blank_clear", {15'd0, blank}, 16'd0);
    wait_cyc(7);
    check("digit8", {12'd0, digit}, 16'd8);

    // Illegal code.
    put(7'h7E); expect_valid(4'hF, 1'b1); wait_cyc(10);
    check("illegal_err", {15'd0, err}, 16'd1);

    // Glitch then re-accept of the same code.
    put(7'h24); expect_valid(4'd5, 1'b0); wait_cyc(10);
    put(7'h20); put(7'h24); expect_valid(4'd5, 1'b0); wait_cyc(10);

    // Hex code A.
    put(7'h08);
`ifdef SEG7_HEX_EN
    expect_valid(4'hA, 1'b0);
`else
    expect_valid(4'hF, 1'b1);
`endif
    wait_cyc(10);
    check("sb_drained_a", sb.size(), 16'd0);

    // Reset mid-settle: no valid until a fresh acceptance.
    put(7'h4C); wait_cyc(2);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_abort_quiet", {15'd0, valid}, 16'd0);
    end
    expect_valid(4'd4, 1'b0);
    @(posedge clk); #1;
    check("rst_reaccept", {15'd0, valid}, 16'd1);
    wait_cyc(5);

    // 256 accepted digits wrap the counter.
    {a, b, c, d, e, f, g} = 7'h7F;
    do_reset();
    wait_cyc(8);
    for (int i = 0; i < 256; i++) begin
      put(codes[i % 10]);
      expect_valid(4'(i % 10), 1'b0);
      wait_cyc(7);
    end
    wait_cyc(4);
    check("wrap_cnt", {8'd0, digit_cnt}, 16'd0);
    check("wrap_digit", {12'd0, digit}, 16'd5);
    check("sb_drained_end", sb.size(), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
